fir4_deconv: RTL and testbench
==============================

FIR4_DECONV -- requirements
Module: fir4_deconv

Interface
REQ-001 Parameter: w, default 16, width of the reconstructed sample; the input sum is w+2 bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  s_in carries a new 4-tap moving-sum sample this cycle.
REQ-005 s_in  input  w+2  unsigned moving sum s[k] = x[k]+x[k-1]+x[k-2]+x[k-3], with x[<0]=0.
REQ-006 clr  input  1  synchronous clear of all history and flags.
REQ-007 out_valid  output  1  x_out holds a reconstructed sample.
REQ-008 x_out  output  w  reconstructed unsigned sample x[k].
REQ-009 err  output  1  sticky: a reconstruction fell outside [0, 2^w-1].

Function
REQ-010 Recurrence: x[k] = s[k] - s[k-1] + x[k-4], with s[-1]=0 and x[k-4]=0 for k<4.
REQ-011 Intermediate arithmetic is signed, w+4 bits; the three-operand sum uses one carry-save stage followed by one carry-propagate adder.
REQ-012 Latency is one cycle: in_valid sampled at edge n gives out_valid=1 and the matching x_out after edge n.
REQ-013 out_valid is a registered copy of in_valid (gated by clr); x_out holds its last value while out_valid=0.
REQ-014 History (s_prev, x[k-1..k-4] shift line) advances only on cycles with in_valid=1; cycles with in_valid=0 change no state except out_valid.
REQ-015 A warm-up counter (0..4, saturating) counts accepted samples; while it is <4, the x[k-4] operand is forced to 0.
REQ-016 The counter stops at 4 and never wraps.
REQ-017 Out of range: an intermediate result <0 or >2^w-1 sets err; err stays set until clr or reset.
REQ-018 The value written into the shift line is the same value driven on x_out, clamped or wrapped per REQ-024/025.
REQ-019 clr=1 zeroes history, counter, err, out_valid and x_out at the next edge; in_valid in that cycle is ignored.
REQ-020 clr and in_valid together: clr wins.

Reset
REQ-021 rst_n low asynchronously zeroes out_valid, x_out, err, the counter, s_prev and the shift line.
REQ-022 Reset asserted mid-stream discards all history; the first sample after release is treated as k=0.
REQ-023 No output toggles while rst_n is low.

Configuration
REQ-024 With FIR4_DECONV_SAT_EN defined, an out-of-range result saturates to 0 (negative) or 2^w-1 (overflow).
REQ-025 Without FIR4_DECONV_SAT_EN, an out-of-range result wraps to its low w bits.
REQ-026 err behaves identically in both builds.

Structure
REQ-027 Package fir4_pkg holds the default width W_DEF=16, TAPS=4, and the derived widths SUM_W=W_DEF+2 and ACC_W=W_DEF+4.
REQ-028 One sub-module, fir4_sub3, is a combinational carry-save plus carry-propagate A-B+C in ACC_W bits; all registers stay in fir4_deconv.

Verification (w=16)
REQ-029 Feed the forward sums of x=1,2,3,4,5,6 (s=1,3,6,10,14,18) on consecutive valid cycles -> x_out=1,2,3,4,5,6, each one cycle later, err=0.
REQ-030 Same stream with in_valid low for 3 cycles between samples 2 and 3 -> identical x_out sequence, out_valid low during the gaps.
REQ-031 Feed s=0 then s=5 then s=0 -> third result is -5: SAT build x_out=0, wrap build x_out=0xFFFB; err=1 in both, holds until clr.
REQ-032 Feed the forward sums of x=65535 repeated (s=65535, 131070, 196605, 262140, 262140, ...) -> x_out=65535 throughout, err=0.
REQ-033 Pulse rst_n low after sample 3, then restart with s=7 -> x_out=7 (warm-up restarted), out_valid low during reset.
REQ-034 Assert clr together with in_valid (s=9) -> no out_valid next cycle; the next sample s=4 gives x_out=4.

Source files
------------

// File: rtl/fir4_pkg.sv
// rtl/fir4_pkg.sv - shared widths and constants for the 4-tap moving-sum deconvolver
package fir4_pkg;

    localparam int W_DEF = 16;
    localparam int TAPS  = 4;
    localparam int SUM_W = W_DEF + 2;
    localparam int ACC_W = W_DEF + 4;

    localparam logic [2:0] WARM_MAX = 3'(TAPS);

endpackage

// File: rtl/fir4_sub3.sv
// rtl/fir4_sub3.sv - combinational y = a - b + c: one carry-save stage, one carry-propagate adder
module fir4_sub3
    import fir4_pkg::*;
#(
    parameter int acc_w = ACC_W
) (
    input  logic [acc_w-1:0] a,
    input  logic [acc_w-1:0] b,
    input  logic [acc_w-1:0] c,
    output logic [acc_w-1:0] y
);

    logic [acc_w-1:0] nb;
    logic [acc_w-1:0] cs_sum;
    logic [acc_w-2:0] cs_maj;
    logic [acc_w-1:0] cs_carry;

    assign nb     = ~b;
    assign cs_sum = a ^ nb ^ c;
    assign cs_maj = (a[acc_w-2:0] & nb[acc_w-2:0])
                  | (a[acc_w-2:0] & c[acc_w-2:0])
                  | (nb[acc_w-2:0] & c[acc_w-2:0]);

    // The vacant LSB of the shifted carry word supplies the +1 that completes -b.
    assign cs_carry = {cs_maj, 1'b1};
    assign y        = cs_sum + cs_carry;

endmodule

// File: rtl/fir4_deconv.sv
// rtl/fir4_deconv.sv - recovers x[k] from 4-tap moving sums, x[k] = s[k] - s[k-1] + x[k-4]
// Define FIR4_DECONV_SAT_EN to saturate out-of-range results instead of wrapping.
module fir4_deconv
    import fir4_pkg::*;
#(
    parameter int w = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [w+1:0] s_in,
    input  logic         clr,
    output logic         out_valid,
    output logic [w-1:0] x_out,
    output logic         err
);

    localparam int AW = w + 4;

    logic [w+1:0]  s_prev;
    logic [w-1:0]  hist [TAPS];
    logic [2:0]    warm_cnt;
    logic          warm_done;

    logic [AW-1:0] op_a;
    logic [AW-1:0] op_b;
    logic [AW-1:0] op_c;
    logic [AW-1:0] acc;
    logic          neg;
    logic          ovf;
    logic [w-1:0]  x_next;

    assign warm_done = (warm_cnt == WARM_MAX);
    assign op_a      = {2'b00, s_in};
    assign op_b      = {2'b00, s_prev};
    assign op_c      = warm_done ? {4'b0000, hist[TAPS-1]} : '0;

    fir4_sub3 #(
        .acc_w (AW)
    ) u_sub3 (
        .a (op_a),
        .b (op_b),
        .c (op_c),
        .y (acc)
    );

    assign neg = acc[AW-1];
    assign ovf = ~neg & (|acc[AW-2:w]);

    always_comb begin
        x_next = acc[w-1:0];
`ifdef FIR4_DECONV_SAT_EN
        if (neg) begin
            x_next = '0;
        end else if (ovf) begin
            x_next = '1;
        end
`endif
    end

    // The shift line stores exactly what is driven on x_out, so a clamped
    // or wrapped value feeds back into later reconstructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            err       <= 1'b0;
            warm_cnt  <= '0;
            s_prev    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else if (clr) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            err       <= 1'b0;
            warm_cnt  <= '0;
            s_prev    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                x_out  <= x_next;
                s_prev <= s_in;
                for (int i = TAPS - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0] <= x_next;
                if (!warm_done) begin
                    warm_cnt <= warm_cnt + 3'd1;
                end
                if (neg || ovf) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir4_deconv.sv
// tb/tb_fir4_deconv.sv - self-checking bench for fir4_deconv (honours FIR4_DECONV_SAT_EN)
module tb_fir4_deconv;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W+1:0] s_in;
    logic         clr;
    logic         out_valid;
    logic [W-1:0] x_out;
    logic         err;

    fir4_deconv #(
        .w (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .s_in      (s_in),
        .clr       (clr),
        .out_valid (out_valid),
        .x_out     (x_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    longint sb_q [$];
    longint m_sprev;
    longint m_h [4];
    int     m_cnt;
    logic   m_err;
    logic   m_ov;
    longint m_x;
    longint last_x;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sprev = 0;
        for (int i = 0; i < 4; i++) m_h[i] = 0;
        m_cnt = 0;
        m_err = 1'b0;
        m_ov  = 1'b0;
        m_x   = 0;
        sb_q.delete();
    endtask

    task automatic model_push(input longint s);
        longint d;
        longint r;
        d = s - m_sprev + ((m_cnt >= 4) ? m_h[3] : 0);
        r = d;
        if (d < 0 || d > 65535) begin
            m_err = 1'b1;
`ifdef FIR4_DECONV_SAT_EN
            r = (d < 0) ? 0 : 65535;
`else
            r = d & 65535;
`endif
        end
        m_h[3] = m_h[2];
        m_h[2] = m_h[1];
        m_h[1] = m_h[0];
        m_h[0] = r;
        m_sprev = s;
        if (m_cnt < 4) m_cnt++;
        sb_q.push_back(r);
    endtask

    task automatic step(input logic v, input longint s, input logic c);
        longint e;
        @(negedge clk);
        in_valid = v;
        s_in     = s[W+1:0];
        clr      = c;
        if (c) begin
            model_reset();
        end else begin
            m_ov = v;
            if (v) model_push(s);
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                m_x = e;
                check("x_out", x_out, e);
                last_x = x_out;
            end
        end else begin
            check("x_hold", x_out, m_x);
        end
        check("err", err, m_err);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        check("rst_hold_out_valid", out_valid, 0);
        check("rst_hold_x_out", x_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        longint seq1 [6];
        seq1[0] = 1;  seq1[1] = 3;  seq1[2] = 6;
        seq1[3] = 10; seq1[4] = 14; seq1[5] = 18;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        s_in     = '0;
        clr      = 1'b0;
        last_x   = 0;
        model_reset();
        pulse_reset();

        // forward sums of 1..6 back to back
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq1[i], 1'b0);
            check("seq_x", last_x, i + 1);
        end
        step(1'b0, 0, 1'b1);

        // same stream with a 3-cycle gap after the second sample
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                for (int g = 0; g < 3; g++) step(1'b0, 99, 1'b0);
            end
            step(1'b1, seq1[i], 1'b0);
            check("gap_x", last_x, i + 1);
        end
        step(1'b0, 0, 1'b1);

        // negative result
        step(1'b1, 0, 1'b0);
        step(1'b1, 5, 1'b0);
        step(1'b1, 0, 1'b0);
`ifdef FIR4_DECONV_SAT_EN
        check("neg_x", last_x, 0);
`else
        check("neg_x", last_x, 16'hFFFB);
`endif
        check("neg_err", err, 1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("err_sticky", err, 1);
        step(1'b0, 0, 1'b1);
        check("err_cleared", err, 0);

        // full-scale constant input
        step(1'b1, 65535, 1'b0);
        step(1'b1, 131070, 1'b0);
        step(1'b1, 196605, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 262140, 1'b0);
            check("max_x", last_x, 65535);
        end
        check("max_err", err, 0);
        step(1'b0, 0, 1'b1);

        // reset mid-stream restarts warm-up
        step(1'b1, 1, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b1, 6, 1'b0);
        pulse_reset();
        step(1'b1, 7, 1'b0);
        check("restart_x", last_x, 7);

        // clr together with in_valid
        step(1'b1, 9, 1'b1);
        step(1'b1, 4, 1'b0);
        check("clr_wins_x", last_x, 4);

        // random traffic against the model
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) != 0), longint'($urandom_range(0, 262143)),
                 ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
